// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: FSM encoding, CP0 register
// numbers, register field positions and exception cause codes.
package exc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REDIR = 2'd1,
      ST_FLUSH = 2'd2
   } exc_state_t;

   // CP0 register numbers
   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   // Field positions inside Status / Cause
   localparam int IM_LSB   = 10;
   localparam int IM_MSB   = 15;
   localparam int IP_LSB   = 10;
   localparam int IP_MSB   = 15;
   localparam int EXL_BIT  = 1;
   localparam int IE_BIT   = 0;
   localparam int CODE_LSB = 2;
   localparam int CODE_MSB = 6;

   // Exception cause codes
   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;

endpackage

// File: rtl/exc_ctrl_cp0_regs.sv
// CP0 Status/Cause/EPC register file with MTC0 write port, hardware update
// ports (hardware wins on collision) and a combinational MFC0 read mux.
module cp0_regs
   import exc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  int_in,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   input  logic        hw_exl_we,
   input  logic        hw_exl_val,
   input  logic        hw_code_we,
   input  logic [4:0]  hw_code_val,
   input  logic        hw_epc_we,
   input  logic [31:0] hw_epc_val,
   output logic [5:0]  im,
   output logic        ie,
   output logic        exl,
   output logic [5:0]  ip,
   output logic [31:0] epc_val
);

   logic [5:0]  im_reg;
   logic        ie_reg;
   logic        exl_reg;
   logic [5:0]  ip_reg;
   logic [4:0]  code_reg;
   logic [31:0] epc_reg;

   logic wr_status;
   logic wr_epc;

   assign wr_status = cp0_we && (cp0_addr == CP0_STATUS);
   assign wr_epc    = cp0_we && (cp0_addr == CP0_EPC);

   // Register updates: IP samples the interrupt lines every cycle; hardware
   // writes to EXL/ExcCode/EPC take precedence over a same-cycle MTC0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         im_reg   <= '0;
         ie_reg   <= 1'b0;
         exl_reg  <= 1'b0;
         ip_reg   <= '0;
         code_reg <= '0;
         epc_reg  <= '0;
      end else begin
         ip_reg <= int_in;
         if (wr_status) begin
            im_reg <= cp0_wdata[IM_MSB:IM_LSB];
            ie_reg <= cp0_wdata[IE_BIT];
         end
         if (hw_exl_we)
            exl_reg <= hw_exl_val;
         else if (wr_status)
            exl_reg <= cp0_wdata[EXL_BIT];
         if (hw_code_we)
            code_reg <= hw_code_val;
         if (hw_epc_we)
            epc_reg <= hw_epc_val;
         else if (wr_epc)
            epc_reg <= cp0_wdata;
      end
   end

   // MFC0 read mux; unimplemented bits and registers read as zero.
   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         CP0_STATUS: begin
            cp0_rdata[IM_MSB:IM_LSB] = im_reg;
            cp0_rdata[EXL_BIT]       = exl_reg;
            cp0_rdata[IE_BIT]        = ie_reg;
         end
         CP0_CAUSE: begin
            cp0_rdata[IP_MSB:IP_LSB]     = ip_reg;
            cp0_rdata[CODE_MSB:CODE_LSB] = code_reg;
         end
         CP0_EPC: cp0_rdata = epc_reg;
         default: cp0_rdata = '0;
      endcase
   end

   assign im      = im_reg;
   assign ie      = ie_reg;
   assign exl     = exl_reg;
   assign ip      = ip_reg;
   assign epc_val = epc_reg;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/return controller: prioritises exception, interrupt and ERET in
// IDLE, issues a one-cycle redirect to the PC mux and holds flush afterwards.
module exc_ctrl
   import exc_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   input  logic        exc_req,
   input  logic [4:0]  exc_code,
   input  logic [5:0]  int_in,
   input  logic        eret,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   output logic        is_exp,
   output logic [31:0] epc,
   output logic        flush
);

   localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

   exc_state_t    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [31:0]   target_reg, target_next;

   logic        take_exc, take_int, take_eret;
   logic [5:0]  im, ip;
   logic        ie, exl;
   logic [31:0] epc_cp0;
   logic        int_pend;

   assign int_pend = (|(ip & im)) & ie & ~exl;

   cp0_regs u_cp0 (
      .clk         (clk),
      .rst         (rst),
      .int_in      (int_in),
      .cp0_we      (cp0_we),
      .cp0_addr    (cp0_addr),
      .cp0_wdata   (cp0_wdata),
      .cp0_rdata   (cp0_rdata),
      .hw_exl_we   (take_exc | take_int | take_eret),
      .hw_exl_val  (~take_eret),
      .hw_code_we  (take_exc | take_int),
      .hw_code_val (take_exc ? exc_code : EXC_INT),
      .hw_epc_we   ((take_exc & ~exl) | take_int),
      .hw_epc_val  (pc_cur),
      .im          (im),
      .ie          (ie),
      .exl         (exl),
      .ip          (ip),
      .epc_val     (epc_cp0)
   );

   // State, flush counter and redirect target registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         target_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         target_reg <= target_next;
      end
   end

   // Trigger priority (only in IDLE) and state sequencing.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      target_next = target_reg;
      take_exc    = 1'b0;
      take_int    = 1'b0;
      take_eret   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (exc_req)
               take_exc = 1'b1;
            else if (int_pend)
               take_int = 1'b1;
            else if (eret && exl)
               take_eret = 1'b1;
            if (take_exc || take_int) begin
               target_next = EXC_VECTOR;
               state_next  = ST_REDIR;
            end else if (take_eret) begin
               target_next = epc_cp0;
               state_next  = ST_REDIR;
            end
         end
         ST_REDIR: begin
            cnt_next   = '0;
            state_next = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
         end
         ST_FLUSH: begin
            if (cnt_reg == CNT_LAST)
               state_next = ST_IDLE;
            else
               cnt_next = cnt_reg + 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign is_exp = (state_reg == ST_REDIR);
   assign flush  = (state_reg != ST_IDLE);
   assign epc    = target_reg;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with default parameters (vector 0x8000_0180,
// two flush cycles). Inputs change 1 ns after the rising edge and outputs are
// checked in that same window.
module tb_exc_ctrl;
   import exc_pkg::*;

   localparam logic [31:0] VEC = 32'h8000_0180;

   logic        clk;
   logic        rst;
   logic [31:0] pc_cur;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic [5:0]  int_in;
   logic        eret;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic        is_exp;
   logic [31:0] epc;
   logic        flush;

   int n_cmp = 0;
   int n_err = 0;

   exc_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .pc_cur    (pc_cur),
      .exc_req   (exc_req),
      .exc_code  (exc_code),
      .int_in    (int_in),
      .eret      (eret),
      .cp0_we    (cp0_we),
      .cp0_addr  (cp0_addr),
      .cp0_wdata (cp0_wdata),
      .cp0_rdata (cp0_rdata),
      .is_exp    (is_exp),
      .epc       (epc),
      .flush     (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      cp0_addr = addr;
      #1;
      check(tag, cp0_rdata, exp);
   endtask

   task automatic outs(input string tag, input logic e_is, input logic [31:0] e_epc, input logic e_fl);
      $display("step %s: is_exp=%0b epc=%h flush=%0b", tag, is_exp, epc, flush);
      check({tag, ".is_exp"}, {31'd0, is_exp}, {31'd0, e_is});
      check({tag, ".epc"}, epc, e_epc);
      check({tag, ".flush"}, {31'd0, flush}, {31'd0, e_fl});
   endtask

   initial begin
      rst = 1'b1; pc_cur = '0; exc_req = 1'b0; exc_code = '0; int_in = '0;
      eret = 1'b0; cp0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0;

      // Reset state
      tick(); tick();
      outs("reset", 1'b0, 32'h0, 1'b0);
      rd("reset.status", CP0_STATUS, 32'h0);
      rd("reset.cause", CP0_CAUSE, 32'h0);
      rd("reset.epcreg", CP0_EPC, 32'h0);
      rst = 1'b0;
      tick();

      // Syscall from pc 0x40
      exc_req = 1'b1; exc_code = EXC_SYS; pc_cur = 32'h40;
      tick();
      exc_req = 1'b0;
      outs("sys.redir", 1'b1, VEC, 1'b1);
      rd("sys.epcreg", CP0_EPC, 32'h40);
      rd("sys.cause", CP0_CAUSE, 32'h20);
      rd("sys.status", CP0_STATUS, 32'h2);
      tick();
      outs("sys.flush", 1'b0, VEC, 1'b1);
      tick();
      outs("sys.idle", 1'b0, VEC, 1'b0);

      // ERET back to 0x40
      eret = 1'b1;
      tick();
      eret = 1'b0;
      outs("eret.redir", 1'b1, 32'h40, 1'b1);
      rd("eret.status", CP0_STATUS, 32'h0);
      tick(); tick();
      outs("eret.idle", 1'b0, 32'h40, 1'b0);

      // Interrupt with IM0 set but IE clear: never taken
      cp0_we = 1'b1; cp0_addr = CP0_STATUS; cp0_wdata = 32'h400;
      tick();
      cp0_we = 1'b0;
      int_in = 6'b000001; pc_cur = 32'h100;
      tick(); tick(); tick();
      outs("int.masked", 1'b0, 32'h40, 1'b0);
      rd("int.cause_ip", CP0_CAUSE, 32'h420);

      // Enable IE: write lands at this edge, interrupt taken on the next
      cp0_we = 1'b1; cp0_addr = CP0_STATUS; cp0_wdata = 32'h401;
      tick();
      cp0_we = 1'b0;
      outs("int.ie_edge", 1'b0, 32'h40, 1'b0);
      tick();
      outs("int.redir", 1'b1, VEC, 1'b1);
      rd("int.epcreg", CP0_EPC, 32'h100);
      rd("int.cause", CP0_CAUSE, 32'h400);
      rd("int.status", CP0_STATUS, 32'h403);
      int_in = '0;
      tick(); tick();
      eret = 1'b1;
      tick();
      eret = 1'b0;
      outs("int.eret", 1'b1, 32'h100, 1'b1);
      tick(); tick();
      cp0_we = 1'b1; cp0_addr = CP0_STATUS; cp0_wdata = 32'h0;
      tick();
      cp0_we = 1'b0;

      // Simultaneous exc_req and eret: exception wins
      exc_req = 1'b1; eret = 1'b1; exc_code = EXC_OV; pc_cur = 32'h300;
      tick();
      exc_req = 1'b0; eret = 1'b0;
      outs("simul.redir", 1'b1, VEC, 1'b1);
      tick();
      // exc_req during FLUSH is ignored
      exc_req = 1'b1; exc_code = EXC_RI; pc_cur = 32'h500;
      tick();
      exc_req = 1'b0;
      outs("simul.flushreq", 1'b0, VEC, 1'b0);
      rd("simul.cause", CP0_CAUSE, 32'h30);
      rd("simul.epcreg", CP0_EPC, 32'h300);

      // Nested exception with EXL=1: EPC preserved
      cp0_we = 1'b1; cp0_addr = CP0_EPC; cp0_wdata = 32'h40;
      tick();
      cp0_we = 1'b0;
      exc_req = 1'b1; exc_code = EXC_RI; pc_cur = 32'h200;
      tick();
      exc_req = 1'b0;
      outs("nest.redir", 1'b1, VEC, 1'b1);
      rd("nest.epcreg", CP0_EPC, 32'h40);
      rd("nest.cause", CP0_CAUSE, 32'h28);
      rd("nest.status", CP0_STATUS, 32'h2);
      tick(); tick();
      eret = 1'b1;
      tick();
      eret = 1'b0;
      outs("nest.eret", 1'b1, 32'h40, 1'b1);
      tick(); tick();
      // ERET with EXL=0 ignored
      eret = 1'b1;
      tick();
      eret = 1'b0;
      outs("eret.noexl", 1'b0, 32'h40, 1'b0);

      // MTC0 to EPC colliding with hardware EPC update: hardware wins
      exc_req = 1'b1; exc_code = EXC_OV; pc_cur = 32'h600;
      cp0_we = 1'b1; cp0_addr = CP0_EPC; cp0_wdata = 32'h999;
      tick();
      exc_req = 1'b0; cp0_we = 1'b0;
      outs("coll.redir", 1'b1, VEC, 1'b1);
      rd("coll.epcreg", CP0_EPC, 32'h600);

      // Async reset in FLUSH
      tick();
      outs("areset.pre", 1'b0, VEC, 1'b1);
      #1 rst = 1'b1;
      #1;
      outs("areset.now", 1'b0, 32'h0, 1'b0);
      rd("areset.status", CP0_STATUS, 32'h0);
      rd("areset.epcreg", CP0_EPC, 32'h0);
      rst = 1'b0;
      exc_req = 1'b1; exc_code = EXC_SYS; pc_cur = 32'h44;
      tick();
      exc_req = 1'b0;
      outs("areset.after", 1'b1, VEC, 1'b1);
      rd("areset.epc2", CP0_EPC, 32'h44);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
